// File: rtl/multicycle_control.sv
// Moore control unit for the multi-cycle MIPS-subset CPU plus a retired-instruction counter.
// Outputs are combinational from State/OpCode (0-cycle); 2-5 cycles per instruction, no backpressure.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [5:0]       OpCode,
    input  logic             Zero,
    output logic [2:0]       State,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic [1:0]       ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             RegWre,
    output logic [1:0]       WrRegDst,
    output logic             DBDataSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic [CNT_W-1:0] InsCount
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_B  = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT = 6'b100110, OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001, OP_BEQ = 6'b110100, OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;

    state_e           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_al, is_ls, is_jmp;
    logic [2:0] al_op;
    logic       pcwre_c, regwre_c, mwr_c;

    always_comb begin
        is_al = 1'b1;
        al_op = 3'b000;
        unique case (OpCode)
            OP_ADD, OP_ADDI: al_op = 3'b000;
            OP_SUB:          al_op = 3'b001;
            OP_SLL:          al_op = 3'b010;
            OP_OR, OP_ORI:   al_op = 3'b011;
            OP_AND:          al_op = 3'b100;
            OP_SLT:          al_op = 3'b110;
            default:         is_al = 1'b0;
        endcase
    end

    assign is_ls  = (OpCode == OP_LW) || (OpCode == OP_SW);
    assign is_jmp = (OpCode == OP_J) || (OpCode == OP_JR) || (OpCode == OP_JAL);

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            unique case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    if (OpCode == OP_HALT) begin
                        state_d = S_IF;
                        halt_d  = 1'b1;
                    end else if (OpCode == OP_BEQ) begin
                        state_d = S_EXE_B;
                    end else if (is_ls) begin
                        state_d = S_EXE_LS;
                    end else if (is_al) begin
                        state_d = S_EXE_AL;
                    end else begin
                        state_d = S_IF;
                    end
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_EXE_LS: state_d = S_MEM;
                S_MEM:    state_d = (OpCode == OP_LW) ? S_WB_L : S_IF;
                default:  state_d = S_IF;
            endcase
        end
    end

    always_comb begin
        pcwre_c   = 1'b0;
        regwre_c  = 1'b0;
        mwr_c     = 1'b0;
        IRWre     = 1'b0;
        ExtSel    = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        WrRegDst  = 2'b00;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        PCSrc     = 2'b00;
        if (!halt_q) begin
            unique case (state_q)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (OpCode == OP_JR) begin
                        PCSrc   = 2'b10;
                        pcwre_c = 1'b1;
                    end else if (OpCode == OP_J || OpCode == OP_JAL) begin
                        PCSrc    = 2'b11;
                        pcwre_c  = 1'b1;
                        regwre_c = (OpCode == OP_JAL);
                    end else if (!is_jmp && !is_al && !is_ls &&
                                 OpCode != OP_BEQ && OpCode != OP_HALT) begin
                        pcwre_c = 1'b1;
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUOp = al_op;
                    if (OpCode == OP_ADDI) begin
                        ALUSrcB = 1'b1;
                        ExtSel  = 2'b10;
                    end else if (OpCode == OP_ORI) begin
                        ALUSrcB = 1'b1;
                        ExtSel  = 2'b01;
                    end else if (OpCode == OP_SLL) begin
                        ALUSrcA = 1'b1;
                    end
                    if (state_q == S_WB_AL) begin
                        regwre_c = 1'b1;
                        pcwre_c  = 1'b1;
                        WrRegDst = (OpCode == OP_ADDI || OpCode == OP_ORI) ? 2'b01 : 2'b10;
                    end
                end
                S_EXE_B: begin
                    ALUOp   = 3'b001;
                    ExtSel  = 2'b10;
                    pcwre_c = 1'b1;
                    PCSrc   = Zero ? 2'b01 : 2'b00;
                end
                default: begin
                    // Address computation stays selected through MEM and WB_L
                    ALUSrcB = 1'b1;
                    ExtSel  = 2'b10;
                    if (state_q == S_MEM) begin
                        mwr_c   = (OpCode == OP_SW);
                        mRD     = (OpCode == OP_LW);
                        pcwre_c = (OpCode == OP_SW);
                    end else if (state_q == S_WB_L) begin
                        mRD       = 1'b1;
                        DBDataSrc = 1'b1;
                        regwre_c  = 1'b1;
                        WrRegDst  = 2'b01;
                        pcwre_c   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Writes are gated by reset so nothing commits while RST_n is held low
    assign PCWre    = pcwre_c & RST_n;
    assign RegWre   = regwre_c & RST_n;
    assign mWR      = mwr_c & RST_n;
    assign InsMemRW = 1'b1;
    assign State    = state_q;
    assign InsCount = cnt_q;
    assign cnt_d    = PCWre ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its states.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [5:0]  OpCode;
    logic        Zero;
    logic [2:0]  State;
    logic        PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, RegWre, DBDataSrc, mRD, mWR;
    logic [1:0]  ExtSel, WrRegDst, PCSrc;
    logic [2:0]  ALUOp;
    logic [31:0] InsCount;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .CLK(CLK), .RST_n(RST_n), .OpCode(OpCode), .Zero(Zero), .State(State),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre),
        .WrRegDst(WrRegDst), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
        .PCSrc(PCSrc), .InsCount(InsCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_n  = 1'b0;
        OpCode = 6'b000000;
        Zero   = 1'b0;
        #12;
        chk("rst_state", State, 3'd0);
        chk("rst_irwre", IRWre, 1);
        chk("rst_insmem", InsMemRW, 1);
        chk("rst_pcwre", PCWre, 0);
        chk("rst_cnt", InsCount, 0);

        // add
        @(posedge CLK); #1; RST_n = 1'b1;
        chk("add_if", State, 3'd0);
        tick; chk("add_id", State, 3'd1);
        chk("add_id_pcwre", PCWre, 0);
        tick; chk("add_exe", State, 3'd6);
        chk("add_exe_regwre", RegWre, 0);
        tick; chk("add_wb", State, 3'd7);
        chk("add_wb_regwre", RegWre, 1);
        chk("add_wb_dst", WrRegDst, 2'b10);
        chk("add_wb_pcwre", PCWre, 1);
        tick; chk("add_ret", State, 3'd0);
        chk("add_cnt", InsCount, 1);

        // ori
        OpCode = 6'b010010;
        tick; chk("ori_id", State, 3'd1);
        tick; chk("ori_exe", State, 3'd6);
        chk("ori_exe_ext", ExtSel, 2'd1);
        chk("ori_exe_srcb", ALUSrcB, 1);
        chk("ori_exe_aluop", ALUOp, 3'b011);
        tick; chk("ori_wb_ext", ExtSel, 2'd1);
        chk("ori_wb_srcb", ALUSrcB, 1);
        chk("ori_wb_dst", WrRegDst, 2'b01);
        tick; chk("ori_cnt", InsCount, 2);

        // sll
        OpCode = 6'b011000;
        tick; tick;
        chk("sll_exe", State, 3'd6);
        chk("sll_ext", ExtSel, 2'd0);
        chk("sll_srca", ALUSrcA, 1);
        chk("sll_aluop", ALUOp, 3'b010);
        tick; chk("sll_wb_dst", WrRegDst, 2'b10);
        tick; chk("sll_cnt", InsCount, 3);

        // lw: five cycles
        OpCode = 6'b110001;
        tick; tick;
        chk("lw_exe", State, 3'd2);
        chk("lw_exe_ext", ExtSel, 2'd2);
        chk("lw_exe_aluop", ALUOp, 3'b000);
        tick; chk("lw_mem", State, 3'd3);
        chk("lw_mem_mrd", mRD, 1);
        chk("lw_mem_pcwre", PCWre, 0);
        chk("lw_mem_ext", ExtSel, 2'd2);
        tick; chk("lw_wb", State, 3'd4);
        chk("lw_wb_dbsrc", DBDataSrc, 1);
        chk("lw_wb_regwre", RegWre, 1);
        chk("lw_wb_dst", WrRegDst, 2'b01);
        chk("lw_wb_ext", ExtSel, 2'd2);
        chk("lw_wb_pcwre", PCWre, 1);
        tick; chk("lw_ret", State, 3'd0);
        chk("lw_cnt", InsCount, 4);

        // sw: four cycles
        OpCode = 6'b110000;
        tick; tick;
        chk("sw_exe_mwr", mWR, 0);
        tick; chk("sw_mem", State, 3'd3);
        chk("sw_mem_mwr", mWR, 1);
        chk("sw_mem_pcwre", PCWre, 1);
        chk("sw_mem_regwre", RegWre, 0);
        tick; chk("sw_ret", State, 3'd0);
        chk("sw_ret_mwr", mWR, 0);
        chk("sw_cnt", InsCount, 5);

        // beq taken / not taken
        OpCode = 6'b110100; Zero = 1'b1;
        tick; tick;
        chk("beqt_state", State, 3'd5);
        chk("beqt_pcsrc", PCSrc, 2'b01);
        chk("beqt_pcwre", PCWre, 1);
        chk("beqt_aluop", ALUOp, 3'b001);
        tick; chk("beqt_ret", State, 3'd0);
        Zero = 1'b0;
        tick; tick;
        chk("beqn_pcsrc", PCSrc, 2'b00);
        chk("beqn_pcwre", PCWre, 1);
        tick; chk("beqn_ret", State, 3'd0);
        chk("beq_cnt", InsCount, 7);

        // jal and an unused opcode
        OpCode = 6'b111010;
        tick; chk("jal_id", State, 3'd1);
        chk("jal_regwre", RegWre, 1);
        chk("jal_dst", WrRegDst, 2'b00);
        chk("jal_pcsrc", PCSrc, 2'b11);
        chk("jal_pcwre", PCWre, 1);
        tick; chk("jal_ret", State, 3'd0);
        OpCode = 6'b101010;
        tick; chk("nop_pcwre", PCWre, 1);
        chk("nop_pcsrc", PCSrc, 2'b00);
        chk("nop_regwre", RegWre, 0);
        tick; chk("nop_ret", State, 3'd0);
        chk("nop_cnt", InsCount, 9);

        // counter wrap: preload all-ones while in IF, retire a j
        OpCode = 6'b111000;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        tick; chk("wrap_pre", InsCount, 32'hFFFF_FFFF);
        chk("j_pcsrc", PCSrc, 2'b11);
        tick; chk("wrap_cnt", InsCount, 0);

        // reset asserted in the middle of lw WB_L
        OpCode = 6'b110001;
        tick; tick; tick; tick;
        chk("lwr_wb", State, 3'd4);
        chk("lwr_wb_regwre", RegWre, 1);
        RST_n = 1'b0;
        #1;
        chk("lwr_state", State, 3'd0);
        chk("lwr_regwre", RegWre, 0);
        chk("lwr_pcwre", PCWre, 0);
        chk("lwr_irwre", IRWre, 1);
        chk("lwr_cnt", InsCount, 0);
        #1 RST_n = 1'b1;
        OpCode = 6'b111010;
        tick; chk("post_rst_id", State, 3'd1);
        tick; chk("post_rst_cnt", InsCount, 1);

        // halt is absorbing
        OpCode = 6'b111111;
        tick; chk("halt_id_pcwre", PCWre, 0);
        tick;
        OpCode = 6'b000000;
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("halt_state_%0d", i), State, 3'd0);
            chk($sformatf("halt_pcwre_%0d", i), PCWre, 0);
            chk($sformatf("halt_cnt_%0d", i), InsCount, 1);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control unit for the multi-cycle MIPS-subset CPU.
- Sequences every instruction through IF/ID/EXE/MEM/WB states.
- Drives all datapath enables and muxes, including the 2-bit selection input of the immediate extender.
- Also keeps a retired-instruction counter for debug and performance readout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  reset, asynchronous, active-low.
- OpCode  input  6  IR[31:26]; stable from ID until the instruction retires.
- Zero  input  1  ALU zero flag, sampled in EXE_B.
- State  output  3  current state encoding.
- PCWre  output  1  PC write enable.
- IRWre  output  1  IR write enable.
- InsMemRW  output  1  instruction memory read (1 = read).
- ExtSel  output  2  extender mode: 0 = shamt zero-extend, 1 = 16-bit zero-extend, 2 = 16-bit sign-extend; 3 is never driven.
- ALUSrcA  output  1  1 = extender output (shamt) to ALU A; 0 = rs.
- ALUSrcB  output  1  1 = extender output to ALU B; 0 = rt.
- ALUOp  output  3  000 A+B, 001 A-B, 010 B<<A, 011 A|B, 100 A&B, 110 signed slt.
- RegWre  output  1  register-file write enable.
- WrRegDst  output  2  00 = $31, 01 = rt, 10 = rd.
- DBDataSrc  output  1  1 = data-memory data to register-file write port; 0 = ALU result.
- mRD  output  1  data memory read enable.
- mWR  output  1  data memory write enable.
- PCSrc  output  2  00 PC+4, 01 PC+4+(sext<<2), 10 rs (jr), 11 jump target.
- InsCount  output  CNT_W  count of retired instructions.

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111. All other opcodes are NOP.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_L 100, EXE_B 101, EXE_AL 110, WB_AL 111, HALT (held separately; State reads 000 with the halt flag set).
- RST_n low:
  - State = IF, halt flag = 0, InsCount = 0. Takes effect immediately, mid-instruction included.
  - All writes (PCWre, RegWre, mWR) are 0 while RST_n is low.
  - After release, the first cycle is IF.
- Transitions, one per clock:
  - IF -> ID.
  - ID -> IF for j, jr, jal, NOP; -> HALT for halt; -> EXE_B for beq; -> EXE_LS for lw/sw; -> EXE_AL for the rest.
  - EXE_AL -> WB_AL -> IF. EXE_B -> IF. EXE_LS -> MEM.
  - MEM -> IF for sw; -> WB_L for lw. WB_L -> IF.
  - HALT is absorbing; only reset leaves it.
- Outputs are combinational from State and OpCode.
  - Every signal not listed in a state is 0 in that state.
  - InsMemRW = 1 in all states.
- IF: IRWre = 1.
- ID:
  - j: PCSrc = 11, PCWre = 1.
  - jr: PCSrc = 10, PCWre = 1.
  - jal: PCSrc = 11, PCWre = 1, RegWre = 1, WrRegDst = 00 (writes PC+4).
  - NOP: PCWre = 1, PCSrc = 00.
- EXE_AL / WB_AL:
  - ALUOp from the opcode table; PCSrc = 00.
  - addi: ALUSrcB = 1, ExtSel = 2.
  - ori: ALUSrcB = 1, ExtSel = 1.
  - sll: ALUSrcA = 1, ExtSel = 0.
  - In WB_AL only: RegWre = 1, PCWre = 1, DBDataSrc = 0; WrRegDst = 01 for addi/ori, 10 otherwise.
- EXE_B:
  - ALUOp = 001, ExtSel = 2, PCWre = 1.
  - PCSrc = 01 if Zero, else 00.
- EXE_LS / MEM / WB_L:
  - ALUOp = 000, ALUSrcB = 1, ExtSel = 2, held through all three states.
  - MEM: mWR = 1 for sw, mRD = 1 for lw; PCWre = 1 for sw.
  - WB_L: mRD = 1, DBDataSrc = 1, RegWre = 1, WrRegDst = 01, PCWre = 1.
- PCWre: exactly one cycle per retired instruction, always in its final state.
- InsCount:
  - Increments on each clock edge where PCWre = 1.
  - Wraps from all-ones to 0.
  - Not incremented by HALT or reset.
- Latency in cycles: j/jr/jal/NOP 2, beq 3, sw 4, R-type/imm 4, lw 5.

Test Plan:
- Reset release, then add 000000: states IF, ID, EXE_AL, WB_AL, IF. RegWre = 1 and WrRegDst = 10 only in WB_AL. InsCount = 1 after 4 cycles.
- ori 010010 then sll 011000:
  - ori: ExtSel = 1 and ALUSrcB = 1 in EXE_AL/WB_AL, WrRegDst = 01.
  - sll: ExtSel = 0, ALUSrcA = 1, ALUOp = 010.
- lw 110001: 5 cycles, ExtSel = 2 from EXE_LS through WB_L, DBDataSrc = 1 in WB_L. sw 110000: mWR = 1 only in MEM, 4 cycles, RegWre never set.
- beq with Zero = 1 -> PCSrc = 01 and PCWre = 1 in EXE_B. With Zero = 0 -> PCSrc = 00. Both return to IF after 3 cycles.
- jal 111010: ID asserts RegWre = 1, WrRegDst = 00, PCSrc = 11; 2 cycles. Opcode 101010 (NOP): ID -> IF with PCWre = 1.
- halt 111111 -> HALT held for 20+ cycles, PCWre = 0, InsCount frozen.
  - RST_n pulsed low mid-WB_L of a lw: outputs go to the IF pattern immediately, RegWre drops, InsCount = 0.
  - InsCount preloaded near all-ones (force) wraps to 0 after the next retired instruction.
